// File: rtl/prio_pkg.sv
// Shared types, mode encodings and width helper for the priority encoder/arbiter.
package prio_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, usable in constant expressions for index widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_arb_if.sv
// Request/grant bundle between requesters/consumer (master) and the arbiter (slave).
interface prio_enc_arb_if #(
    parameter int unsigned N = 8
);
    import prio_pkg::*;

    localparam int unsigned W = clog2(N);

    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic         ack;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_oh;
    logic         err;

    modport master (
        output en, mode, req, ack,
        input  out_valid, out_idx, out_oh, err
    );

    modport slave (
        input  en, mode, req, ack,
        output out_valid, out_idx, out_oh, err
    );

endinterface

// File: rtl/prio_pick.sv
// Combinational pick: rotate requests by ptr, take highest set bit, rotate index back.
// In fixed mode the rotation is zero, so this degenerates to a highest-index encoder.
module prio_pick
    import prio_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [clog2(N)-1:0]  ptr,
    input  logic                 mode,
    output logic [clog2(N)-1:0]  idx,
    output logic                 any
);

    localparam int unsigned W  = clog2(N);
    localparam int unsigned WS = W + 1;

    logic [W-1:0]   eff_ptr;
    logic [N-1:0]   rot;
    logic [2*N-1:0] dbl;
    logic [W-1:0]   hi;
    logic           hit;
    logic [WS-1:0]  sum;

    // rot[j] = req[(j+ptr) mod N]: top bit is ptr-1, bottom bit is ptr (lowest priority).
    always_comb begin
        eff_ptr = '0;
        if (mode == MODE_RR) begin
            eff_ptr = ptr;
        end
        dbl = {req, req};
        rot = N'(dbl >> eff_ptr);
        hi  = '0;
        hit = 1'b0;
        for (int j = 0; j < N; j++) begin
            if ((rot & (N'(1) << j)) != '0) begin
                hi  = W'(j);
                hit = 1'b1;
            end
        end
        sum = WS'(hi) + WS'(eff_ptr);
        if (sum >= WS'(N)) begin
            sum = sum - WS'(N);
        end
        idx = sum[W-1:0];
        any = hit;
    end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority encoder / arbiter with grant lock until ack and RR pointer.
module prio_enc_arb
    import prio_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_enc_arb_if.slave bus
);

    localparam int unsigned W = clog2(N);

    state_t       state, state_n;
    logic         valid_q, valid_n;
    logic [W-1:0] idx_q, idx_n;
    logic [N-1:0] oh_q, oh_n;
    logic         err_q, err_n;
    logic [W-1:0] ptr_q, ptr_n;

    logic [N-1:0] pick_req;
    logic [W-1:0] pick_ptr;
    logic [W-1:0] pick_idx;
    logic         pick_any;

    // On ack the acked requester is masked and the pointer moves to it in the same cycle.
    always_comb begin
        pick_req = bus.req;
        pick_ptr = ptr_q;
        if (state == GRANT) begin
            pick_req = bus.req & ~oh_q;
            pick_ptr = idx_q;
        end
    end

    prio_pick #(.N(N)) u_pick (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .mode (bus.mode),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic; grant is frozen in GRANT until ack.
    always_comb begin
        state_n = state;
        valid_n = valid_q;
        idx_n   = idx_q;
        oh_n    = oh_q;
        err_n   = 1'b0;
        ptr_n   = ptr_q;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    if (pick_any) begin
                        valid_n = 1'b1;
                        idx_n   = pick_idx;
                        oh_n    = N'(1) << pick_idx;
                        state_n = GRANT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    ptr_n = idx_q;
                    if (bus.en && pick_any) begin
                        valid_n = 1'b1;
                        idx_n   = pick_idx;
                        oh_n    = N'(1) << pick_idx;
                    end else begin
                        valid_n = 1'b0;
                        oh_n    = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                valid_n = 1'b0;
                oh_n    = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Output and pointer registers; reset overrides any ack in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            oh_q    <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_n;
            idx_q   <= idx_n;
            oh_q    <= oh_n;
            err_q   <= err_n;
            ptr_q   <= ptr_n;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_oh    = oh_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb with N=8 and N=5 instances and an expectation queue.
module tb_prio_enc_arb;
    import prio_pkg::*;

    typedef struct packed {
        logic       dut5;
        logic       v;
        logic       ci;
        logic [2:0] i;
        logic [7:0] oh;
        logic       e;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    exp_t  exp_q[$];
    string tag_q[$];

    prio_enc_arb_if #(.N(8)) if8 ();
    prio_enc_arb_if #(.N(5)) if5 ();

    prio_enc_arb #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    prio_enc_arb #(.N(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string t, input logic d5, input logic v, input logic ci,
                              input logic [2:0] i, input logic [7:0] oh, input logic er);
        exp_t e;
        e.dut5 = d5;
        e.v    = v;
        e.ci   = ci;
        e.i    = i;
        e.oh   = oh;
        e.e    = er;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Advance one clock, then compare every pending expectation against the DUT.
    task automatic cycle();
        exp_t       e;
        string      t;
        logic       ov;
        logic [2:0] oi;
        logic [7:0] oo;
        logic       oe;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.dut5) begin
                ov = if5.out_valid;
                oi = if5.out_idx;
                oo = 8'(if5.out_oh);
                oe = if5.err;
            end else begin
                ov = if8.out_valid;
                oi = if8.out_idx;
                oo = if8.out_oh;
                oe = if8.err;
            end
            cmp({t, ".valid"}, 8'(ov), 8'(e.v));
            if (e.ci) begin
                cmp({t, ".idx"}, 8'(oi), 8'(e.i));
            end
            cmp({t, ".oh"}, oo, e.oh);
            cmp({t, ".err"}, 8'(oe), 8'(e.e));
        end
    endtask

    task automatic do_reset(input string t);
        rst_n = 1'b0;
        expect_out({t, ".rst8"}, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        expect_out({t, ".rst5"}, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        if8.en = 1'b0; if8.mode = MODE_FIXED; if8.req = '0; if8.ack = 1'b0;
        if5.en = 1'b0; if5.mode = MODE_FIXED; if5.req = '0; if5.ack = 1'b0;
        cycle();
        do_reset("reset");

        // Fixed priority picks the highest set bit.
        if8.en = 1'b1; if8.mode = MODE_FIXED; if8.req = 8'b0010_0110;
        expect_out("t1.grant", 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0);
        cycle();
        if8.req = 8'h00; if8.ack = 1'b1;
        expect_out("t1.drop", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();
        if8.ack = 1'b0; if8.en = 1'b0;

        // Round-robin with all requests and ack every cycle: 7..0 then 7, no bubble.
        do_reset("t2");
        if8.en = 1'b1; if8.mode = MODE_RR; if8.req = 8'hFF;
        expect_out("t2.first", 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0);
        cycle();
        if8.ack = 1'b1;
        for (int k = 6; k >= -1; k--) begin
            int kk;
            kk = (k < 0) ? 7 : k;
            expect_out($sformatf("t2.rr%0d", kk), 1'b0, 1'b1, 1'b1, 3'(kk), 8'(1) << kk, 1'b0);
            cycle();
        end
        if8.en = 1'b0;
        expect_out("t2.drop", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();
        if8.ack = 1'b0;

        // Grant is locked against request changes until ack.
        do_reset("t3");
        if8.en = 1'b1; if8.mode = MODE_FIXED; if8.req = 8'h08;
        expect_out("t3.grant", 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0);
        cycle();
        if8.req = 8'h80; if8.mode = MODE_RR;
        for (int k = 0; k < 5; k++) begin
            expect_out($sformatf("t3.hold%0d", k), 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0);
            cycle();
        end
        if8.mode = MODE_FIXED; if8.ack = 1'b1;
        expect_out("t3.next", 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0);
        cycle();
        if8.req = 8'h00;
        expect_out("t3.drop", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();
        if8.ack = 1'b0;

        // Enabled with no requests raises err for one cycle only.
        if8.en = 1'b1; if8.req = 8'h00;
        expect_out("t4.err", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        cycle();
        if8.en = 1'b0;
        expect_out("t4.clr", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();
        expect_out("t4.quiet", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();

        // Leave ptr at 6, grant 6 again, then reset mid-grant while acking.
        if8.en = 1'b1; if8.mode = MODE_FIXED; if8.req = 8'h40;
        expect_out("t5.g1", 1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 1'b0);
        cycle();
        if8.en = 1'b0; if8.ack = 1'b1;
        expect_out("t5.d1", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();
        if8.ack = 1'b0; if8.en = 1'b1;
        expect_out("t5.g2", 1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 1'b0);
        cycle();
        if8.ack = 1'b1;
        do_reset("t5");
        if8.ack = 1'b0; if8.mode = MODE_RR; if8.req = 8'h41;
        expect_out("t5.ptr0", 1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 1'b0);
        cycle();
        if8.ack = 1'b1;
        expect_out("t5.rr", 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0);
        cycle();
        if8.en = 1'b0;
        expect_out("t5.drop", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();
        if8.ack = 1'b0;

        // N=5 round-robin between requesters 4 and 0 with alternating acks.
        do_reset("t6");
        if5.en = 1'b1; if5.mode = MODE_RR; if5.req = 5'b10001;
        expect_out("t6.g4a", 1'b1, 1'b1, 1'b1, 3'd4, 8'h10, 1'b0);
        cycle();
        if5.ack = 1'b1;
        expect_out("t6.g0a", 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0);
        cycle();
        if5.ack = 1'b0;
        expect_out("t6.h0", 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0);
        cycle();
        if5.ack = 1'b1;
        expect_out("t6.g4b", 1'b1, 1'b1, 1'b1, 3'd4, 8'h10, 1'b0);
        cycle();
        if5.ack = 1'b0;
        expect_out("t6.h4", 1'b1, 1'b1, 1'b1, 3'd4, 8'h10, 1'b0);
        cycle();
        if5.ack = 1'b1;
        expect_out("t6.g0b", 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0);
        cycle();
        if5.en = 1'b0;
        expect_out("t6.drop", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle();
        if5.ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
